// File: rtl/bnn_fm_loader_if.sv
// Bundle between a serial bit source/controller and bnn_fm_loader.
// With BNN_LOADER_PARITY_EN defined the bundle also carries the err pulse.

// Handshake: a payload bit moves on a rising clk edge where s_valid=1 and
// s_ready=1. The source may hold s_valid low for any number of cycles. The
// loader never drops s_ready while waiting, so the source must keep s_data
// stable until the transfer edge.
interface bnn_fm_loader_if;
  logic        start;
  logic        s_valid;
  logic        s_data;
  logic        s_ready;
  logic        busy;
  logic        done;
  logic [26:0] fm_q;
  logic [26:0] wt_q;
  logic [2:0]  dbg_state;
`ifdef BNN_LOADER_PARITY_EN
  logic        err;

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, busy, done, fm_q, wt_q, dbg_state, err
  );

  modport master (
    output start, s_valid, s_data,
    input  s_ready, busy, done, fm_q, wt_q, dbg_state, err
  );
`else
  modport slave (
    input  start, s_valid, s_data,
    output s_ready, busy, done, fm_q, wt_q, dbg_state
  );

  modport master (
    output start, s_valid, s_data,
    input  s_ready, busy, done, fm_q, wt_q, dbg_state
  );
`endif
endinterface

// File: rtl/bnn_fm_loader.sv
// Serial loader for a 3x3x3 binary feature map and kernel. It double-buffers through private shadows and commits both atomically.
// Optional trailing even-parity bit check: define BNN_LOADER_PARITY_EN.
module bnn_fm_loader #(
  parameter logic [26:0] FM_INIT = 27'h0,
  parameter logic [26:0] WT_INIT = 27'h0
) (
  input  logic            clk,
  input  logic            rst,
  bnn_fm_loader_if.slave  bus
);

`ifdef BNN_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_FM = 3'd1,
    S_LOAD_WT = 3'd2,
    S_COMMIT  = 3'd3,
    S_PARITY  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_FM = 3'd1,
    S_LOAD_WT = 3'd2,
    S_COMMIT  = 3'd3
  } state_t;
`endif

  localparam logic [5:0] LAST_BIT = 6'd26;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [26:0] shadow_fm_q;
  logic [26:0] shadow_wt_q;
  logic [26:0] fm_out_q;
  logic [26:0] wt_out_q;
  logic        s_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        xfer;
  logic        last_bit;

  assign xfer     = bus.s_valid & s_ready_q;
  assign last_bit = (cnt_q == LAST_BIT);

`ifdef BNN_LOADER_PARITY_EN
  logic err_q;
  logic parity_ok;

  // Even parity: the 54 payload bits plus the check bit XOR to zero.
  assign parity_ok = ~(^shadow_fm_q ^ ^shadow_wt_q ^ bus.s_data);
  assign bus.err   = err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      shadow_fm_q <= 27'd0;
      shadow_wt_q <= 27'd0;
      fm_out_q    <= FM_INIT;
      wt_out_q    <= WT_INIT;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BNN_LOADER_PARITY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef BNN_LOADER_PARITY_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          // The done cycle is still the tail of the commit, so a start
          // coinciding with done is dropped.
          if (bus.start && !done_q) begin
            state_q   <= S_LOAD_FM;
            cnt_q     <= 6'd0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        S_LOAD_FM: begin
          if (xfer) begin
            shadow_fm_q[cnt_q[4:0]] <= bus.s_data;
            if (last_bit) begin
              state_q <= S_LOAD_WT;
              cnt_q   <= 6'd0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end

        S_LOAD_WT: begin
          if (xfer) begin
            shadow_wt_q[cnt_q[4:0]] <= bus.s_data;
            if (last_bit) begin
              cnt_q <= 6'd0;
`ifdef BNN_LOADER_PARITY_EN
              state_q   <= S_PARITY;
`else
              state_q   <= S_COMMIT;
              s_ready_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end

`ifdef BNN_LOADER_PARITY_EN
        S_PARITY: begin
          if (xfer) begin
            s_ready_q <= 1'b0;
            if (parity_ok) begin
              state_q <= S_COMMIT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        S_COMMIT: begin
          fm_out_q  <= shadow_fm_q;
          wt_out_q  <= shadow_wt_q;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
          cnt_q     <= 6'd0;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end

        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= 6'd0;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fm_q      = fm_out_q;
  assign bus.wt_q      = wt_out_q;
  assign bus.dbg_state = state_q;

endmodule
